ambulance: RTL and testbench

- Siren-tone generator: drives a 1-bit square wave to a piezo/speaker pin.
- Pitch sweeps up and down in a continuous triangular ramp.
- A free-running sweep accumulator ("tone") selects the half-period of a reloadable down-counter ("counter"); the speaker toggles on each counter expiry.
- Sits at board top level, clocked directly from the 100 MHz system clock.

---
 rtl/ambulance.sv | 38 +++
 tb/tb_ambulance.sv | 113 +++++++++++
 2 files changed

// File: rtl/ambulance.sv
// Siren-tone generator: a free-running sweep accumulator picks the half-period
// of a reloadable down-counter, and the speaker toggles on every counter expiry.
module ambulance #(
  parameter int TONE_WIDTH    = 24,
  parameter int COUNTER_WIDTH = 15
) (
  input  logic clk,
  input  logic reset,
  output logic speaker
);

  logic [TONE_WIDTH-1:0]    tone;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [6:0]               w_ramp;
  logic [COUNTER_WIDTH-1:0] w_divider;

  // Inverting the upper bits while the MSB is clear folds the sawtooth into a triangle.
  assign w_ramp    = tone[TONE_WIDTH-1] ? tone[TONE_WIDTH-2 -: 7] : ~tone[TONE_WIDTH-2 -: 7];
  assign w_divider = COUNTER_WIDTH'({2'b01, w_ramp, 6'b000000});

  always_ff @(posedge clk) begin
    if (reset) begin
      tone    <= '0;
      counter <= '0;
      speaker <= 1'b0;
    end else begin
      tone <= tone + TONE_WIDTH'(1);
      // The divider is captured only at expiry, so the half-period in flight never changes.
      if (counter == '0) begin
        counter <= w_divider;
        speaker <= ~speaker;
      end else begin
        counter <= counter - COUNTER_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ambulance.sv
// Bench for ambulance: full-size instance plus a narrow-sweep instance (fast wrap),
// both checked every cycle against an event-based reload-schedule model.
module tb_ambulance;

  logic clk = 1'b0;
  logic reset;
  logic spkMain;
  logic spkSmall;

  int nChecks = 0;
  int nFails  = 0;

  // Model state per instance: edges since reset, absolute edge of next reload, speaker level.
  longint k[2];
  longint nextReload[2];
  bit     spk[2];
  int     toneW[2] = '{24, 16};

  always #5 clk = ~clk;

  ambulance dut (
    .clk     (clk),
    .reset   (reset),
    .speaker (spkMain)
  );

  ambulance #(.TONE_WIDTH(16), .COUNTER_WIDTH(15)) dutS (
    .clk     (clk),
    .reset   (reset),
    .speaker (spkSmall)
  );

  // Half-period minus one, straight from the triangle-sweep description.
  function automatic longint divOf(longint t, int w);
    longint top;
    longint r7;
    longint ramp;
    top  = (t >> (w - 1)) & 1;
    r7   = (t >> (w - 8)) & 127;
    ramp = (top == 1) ? r7 : 127 - r7;
    return 8192 + ramp * 64;
  endfunction

  task automatic modelEdge(input bit rst);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i]          = 0;
        nextReload[i] = 1;
        spk[i]        = 1'b0;
      end else begin
        k[i] = k[i] + 1;
        if (k[i] == nextReload[i]) begin
          nextReload[i] = k[i] + divOf(k[i] - 1, toneW[i]) + 1;
          spk[i]        = ~spk[i];
        end
      end
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    longint mask;
    mask = (longint'(1) << toneW[0]) - 1;
    check("main.tone",    longint'(dut.tone),    k[0] & mask);
    check("main.counter", longint'(dut.counter), nextReload[0] - 1 - k[0]);
    check("main.speaker", longint'(spkMain),     longint'(spk[0]));
    mask = (longint'(1) << toneW[1]) - 1;
    check("small.tone",    longint'(dutS.tone),    k[1] & mask);
    check("small.counter", longint'(dutS.counter), nextReload[1] - 1 - k[1]);
    check("small.speaker", longint'(spkSmall),     longint'(spk[1]));
  endtask

  task automatic applyStimulus(input bit rst, input int n);
    for (int c = 0; c < n; c++) begin
      if (nFails > 20) break;
      reset = rst;
      @(posedge clk);
      modelEdge(rst);
      @(negedge clk);
      checkOutput();
    end
  endtask

  initial begin
    int midRun;
    int rstLen;
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 3);

    midRun = int'($urandom_range(100, 16000));
    $display("[TB] running %0d cycles before mid-operation reset", midRun);
    applyStimulus(1'b0, midRun);

    rstLen = int'($urandom_range(1, 3));
    applyStimulus(1'b1, rstLen);

    // Long enough for the narrow instance to sweep past its tone wrap.
    applyStimulus(1'b0, 66000 + int'($urandom_range(0, 9000)));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
